// File: rtl/mem_stage_if.sv
// mem_stage_if: data-RAM request/acknowledge port with byte strobes
interface mem_stage_if;
   logic        req;
   logic        wr;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, wr, wstrb, addr, wdata, input ack, rdata);
   modport slave  (input req, wr, wstrb, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage driving a req/ack data RAM; loads extended, stores lane-replicated
// Optional MEM_ALIGN_CHECK_EN flags misaligned half/word accesses as addr_error instead of issuing them.
module mem_stage (
   input  logic         clk,
   input  logic         resetn,
   input  logic         MEM_valid,
   input  logic [159:0] EXE_MEM_bus_r,
   input  logic         MEM_next,
   output logic         MEM_over,
   output logic [152:0] MEM_WB_bus,
   output logic [4:0]   MEM_wdest,
   output logic         MEM_rf_wen,
   output logic [31:0]  MEM_pc,
   mem_stage_if.master  dm
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   state_t state, state_nx;
   logic [7:0]  mem_control, cp0r_addr;
   logic [31:0] store_data, exe_result, lo_result, pc;
   logic        hi_write, lo_write, mfhi, mflo, mtc0, mfc0, syscall, eret, rf_wen, fetch_error, overflow;
   logic [4:0]  rf_wdest;
   logic        load, store, is_mem, half, word, addr_error, go, cancel, unused;
   logic [31:0] badvaddr, sh_b, sh_h, load_data, mem_result;
   logic [3:0]  wstrb_c;
   logic [31:0] wdata_c, rdata_r;
   assign {mem_control, store_data, exe_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0,
           cp0r_addr, syscall, eret, rf_wen, rf_wdest, fetch_error, overflow, pc} = EXE_MEM_bus_r;
   assign unused = ^mem_control[2:0];
   assign load   = mem_control[7];
   assign store  = mem_control[6] & !load;
   assign is_mem = mem_control[7] | mem_control[6];
   assign half   = mem_control[5:4] == 2'b01;
   assign word   = mem_control[5];
`ifdef MEM_ALIGN_CHECK_EN
   assign addr_error = is_mem & ((half & exe_result[0]) | (word & |exe_result[1:0]));
   assign badvaddr   = addr_error ? exe_result : 32'd0;
`else
   assign addr_error = 1'b0;
   assign badvaddr   = 32'd0;
`endif
   assign go = MEM_valid & is_mem & !addr_error;
   // misaligned low bits are ignored: word uses the aligned address, half uses addr[1]
   assign wstrb_c = !store ? 4'b0000 : word ? 4'b1111 : half ? (exe_result[1] ? 4'b1100 : 4'b0011)
                  : 4'b0001 << exe_result[1:0];
   assign wdata_c = word ? store_data : half ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
   assign sh_b = rdata_r >> {exe_result[1:0], 3'b000};
   assign sh_h = rdata_r >> {exe_result[1], 4'b0000};
   assign load_data = word ? rdata_r
                    : half ? {{16{mem_control[3] & sh_h[15]}}, sh_h[15:0]}
                    : {{24{mem_control[3] & sh_b[7]}}, sh_b[7:0]};
   assign mem_result = (load & !addr_error) ? load_data : exe_result;
   assign MEM_rf_wen = rf_wen & !addr_error;
   assign MEM_wdest  = rf_wdest & {5{MEM_valid}};
   assign MEM_pc     = pc;
   assign MEM_WB_bus = {MEM_rf_wen, rf_wdest, mem_result, lo_result, hi_write, lo_write, mfhi, mflo, mtc0, mfc0,
                        cp0r_addr, syscall, eret, fetch_error, overflow, addr_error, badvaddr, pc};
   always_comb begin
      state_nx = state;
      MEM_over = 1'b0;
      case (state)
         IDLE: begin
            MEM_over = MEM_valid & !go;
            state_nx = go ? REQ : IDLE;
         end
         // a flushed request still waits for its ack; the returned data is dropped
         REQ:  state_nx = dm.ack ? ((cancel | !MEM_valid) ? IDLE : DONE) : REQ;
         DONE: begin
            MEM_over = 1'b1;
            state_nx = (MEM_next | !MEM_valid) ? IDLE : DONE;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         cancel   <= 1'b0;
         dm.req   <= 1'b0;
         dm.wr    <= 1'b0;
         dm.wstrb <= 4'b0000;
         dm.addr  <= 32'd0;
         dm.wdata <= 32'd0;
         rdata_r  <= 32'd0;
      end else begin
         state  <= state_nx;
         cancel <= (state == REQ) & !dm.ack & (cancel | !MEM_valid);
         if (state == IDLE && go) begin
            dm.req   <= 1'b1;
            dm.wr    <= store;
            dm.wstrb <= wstrb_c;
            dm.addr  <= {exe_result[31:2], 2'b00};
            dm.wdata <= wdata_c;
         end else if (state == REQ && dm.ack) begin
            dm.req   <= 1'b0;
            dm.wr    <= 1'b0;
            dm.wstrb <= 4'b0000;
         end
         if (state == REQ && dm.ack && !cancel && MEM_valid) rdata_r <= dm.rdata;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, corner sequences and randomized checks of mem_stage against a spec model
module tb_mem_stage;
   typedef struct packed {
      logic [7:0]  mc;
      logic [31:0] sd, res, lo;
      logic        hi_w, lo_w, mfhi, mflo, mtc0, mfc0;
      logic [7:0]  cp0;
      logic        sys, eret, wen;
      logic [4:0]  dest;
      logic        fe, ov;
      logic [31:0] pc;
   } exe_t;
   typedef struct {
      int          over_cyc, req_cyc;
      bit          unstable;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr, wdata;
      logic [152:0] wb;
      logic [4:0]  wdest;
      logic        rfwen;
      logic [31:0] pc;
   } rec_t;
   typedef struct {
      string       name;
      logic [7:0]  mc;
      logic [31:0] sd, res, rd;
      int          waits, over;
      logic [31:0] result;
      logic [3:0]  wstrb;
      logic [31:0] wdata, addr;
   } vec_t;

   logic clk, resetn, MEM_valid, MEM_next, MEM_over, MEM_rf_wen;
   exe_t bus;
   logic [152:0] MEM_WB_bus;
   logic [4:0] MEM_wdest;
   logic [31:0] MEM_pc;
   int total, bad;
   mem_stage_if dm_bus();

   mem_stage dut (.clk(clk), .resetn(resetn), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(bus),
                  .MEM_next(MEM_next), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
                  .MEM_wdest(MEM_wdest), .MEM_rf_wen(MEM_rf_wen), .MEM_pc(MEM_pc), .dm(dm_bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [152:0] act, input logic [152:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   // ---- reference model: sizes, lanes and extensions computed arithmetically ----
   function automatic int nbytes(exe_t b);
      return b.mc[5:4] == 2'b00 ? 1 : b.mc[5:4] == 2'b01 ? 2 : 4;
   endfunction
   function automatic bit is_err(exe_t b);
`ifdef MEM_ALIGN_CHECK_EN
      return (b.mc[7] | b.mc[6]) && (b.res % nbytes(b)) != 0;
`else
      return 0;
`endif
   endfunction
   function automatic int lane(exe_t b);
      return int'(b.res % 4) / nbytes(b) * nbytes(b);
   endfunction
   function automatic logic [31:0] load_val(exe_t b, logic [31:0] rd);
      logic [31:0] v, m;
      v = rd >> (8 * lane(b));
      if (nbytes(b) < 4) begin
         m = (32'd1 << (8 * nbytes(b))) - 32'd1;
         v = v & m;
         if (b.mc[3] && v > (m >> 1)) v = v | ~m;
      end
      return v;
   endfunction
   function automatic bit exp_req(exe_t b);
      return (b.mc[7] | b.mc[6]) && !is_err(b);
   endfunction
   function automatic logic [3:0] exp_wstrb(exe_t b);
      logic [31:0] s;
      s = ((32'd1 << nbytes(b)) - 32'd1) << lane(b);
      return (b.mc[6] && !b.mc[7] && exp_req(b)) ? s[3:0] : 4'd0;
   endfunction
   function automatic logic [31:0] exp_wdata(exe_t b);
      return nbytes(b) == 1 ? {24'd0, b.sd[7:0]} * 32'h0101_0101
           : nbytes(b) == 2 ? {16'd0, b.sd[15:0]} * 32'h0001_0001 : b.sd;
   endfunction
   function automatic logic [152:0] exp_wb(exe_t b, logic [31:0] rd);
      bit e;
      logic [31:0] mr;
      e  = is_err(b);
      mr = (b.mc[7] && !e) ? load_val(b, rd) : b.res;
      return {b.wen & !e, b.dest, mr, b.lo, b.hi_w, b.lo_w, b.mfhi, b.mflo, b.mtc0, b.mfc0, b.cp0,
              b.sys, b.eret, b.fe, b.ov, e, e ? b.res : 32'd0, b.pc};
   endfunction
   function automatic exe_t mk(logic [7:0] mc, logic [31:0] sd, logic [31:0] res);
      exe_t b;
      b = exe_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
      b.mc = mc;
      b.sd = sd;
      b.res = res;
      return b;
   endfunction

   // Runs one instruction from IDLE with a RAM that acks after `waits` request cycles;
   // enters and leaves at posedge+1, accepting the result the cycle MEM_over is seen.
   task automatic do_mem(input exe_t b, input int waits, input logic [31:0] rd, output rec_t r);
      int reqcnt;
      r.over_cyc = -1; r.req_cyc = 0; r.unstable = 0; r.wr = 0; r.wstrb = 0; r.addr = 0; r.wdata = 0;
      r.wb = 0; r.wdest = 0; r.rfwen = 0; r.pc = 0;
      reqcnt = 0;
      bus = b; MEM_valid = 1; MEM_next = 0; dm_bus.ack = 0; dm_bus.rdata = rd;
      for (int k = 0; k < 40 && r.over_cyc < 0; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (dm_bus.req) begin
            if (reqcnt == 0) {r.wr, r.wstrb, r.addr, r.wdata} = {dm_bus.wr, dm_bus.wstrb, dm_bus.addr, dm_bus.wdata};
            else if ({r.wr, r.wstrb, r.addr, r.wdata} !== {dm_bus.wr, dm_bus.wstrb, dm_bus.addr, dm_bus.wdata})
               r.unstable = 1;
            dm_bus.ack = (reqcnt == waits);
            reqcnt++;
         end else dm_bus.ack = 0;
         @(negedge clk);
         if (MEM_over) begin
            r.over_cyc = k; r.wb = MEM_WB_bus; r.wdest = MEM_wdest; r.rfwen = MEM_rf_wen; r.pc = MEM_pc;
            MEM_next = 1;
         end
      end
      r.req_cyc = reqcnt;
      @(posedge clk); #1;
      MEM_next = 0; MEM_valid = 0; dm_bus.ack = 0;
   endtask

   vec_t tv[12];
   rec_t r;
   exe_t b;
   int overs, reqs, w;
   logic [31:0] rd;

   initial begin
      total = 0; bad = 0;
      tv[0]  = '{"lb",    8'h88, 32'h0,        32'h103, 32'h80FF_1234, 0, 2, 32'hFFFF_FF80, 4'h0, 32'h0,        32'h100};
      tv[1]  = '{"sh",    8'h50, 32'h0000_ABCD, 32'h202, 32'h0,        3, 5, 32'h202,       4'hC, 32'hABCD_ABCD, 32'h200};
      tv[2]  = '{"addu",  8'h00, 32'h0,        32'h55,  32'h0,        0, 0, 32'h55,        4'h0, 32'h0,        32'h0};
      tv[3]  = '{"lbu",   8'h80, 32'h0,        32'h101, 32'h80FF_1234, 1, 3, 32'h12,        4'h0, 32'h0,        32'h100};
      tv[4]  = '{"lh",    8'h98, 32'h0,        32'h102, 32'h80FF_1234, 0, 2, 32'hFFFF_80FF, 4'h0, 32'h0,        32'h100};
      tv[5]  = '{"lhu",   8'h90, 32'h0,        32'h100, 32'h80FF_1234, 2, 4, 32'h1234,      4'h0, 32'h0,        32'h100};
      tv[6]  = '{"lw",    8'hA0, 32'h0,        32'h104, 32'h80FF_1234, 0, 2, 32'h80FF_1234, 4'h0, 32'h0,        32'h104};
      tv[7]  = '{"sb3",   8'h40, 32'h1234_56A5, 32'h3,   32'h0,        1, 3, 32'h3,         4'h8, 32'hA5A5_A5A5, 32'h0};
      tv[8]  = '{"sw",    8'h60, 32'hDEAD_BEEF, 32'h10,  32'h0,        2, 4, 32'h10,        4'hF, 32'hDEAD_BEEF, 32'h10};
      tv[9]  = '{"ldst",  8'hF8, 32'h0,        32'h20,  32'hCAFE_F00D, 0, 2, 32'hCAFE_F00D, 4'h0, 32'h0,        32'h20};
      tv[10] = '{"sb1",   8'h40, 32'h77,       32'h41,  32'h0,        0, 2, 32'h41,        4'h2, 32'h7777_7777, 32'h40};
      tv[11] = '{"sh0",   8'h50, 32'h1234_BEEF, 32'h8,   32'h0,        0, 2, 32'h8,         4'h3, 32'hBEEF_BEEF, 32'h8};
      resetn = 0; MEM_valid = 0; MEM_next = 0; bus = '0; dm_bus.ack = 0; dm_bus.rdata = 0;
      repeat (2) @(negedge clk);
      chk("reset_req", dm_bus.req, 0);
      chk("reset_wr_wstrb", {dm_bus.wr, dm_bus.wstrb}, 0);
      chk("reset_over", MEM_over, 0);
      resetn = 1;
      @(posedge clk); #1;
      foreach (tv[i]) begin
         b = mk(tv[i].mc, tv[i].sd, tv[i].res);
         do_mem(b, tv[i].waits, tv[i].rd, r);
         chk({tv[i].name, "_over_cycle"}, r.over_cyc, tv[i].over);
         chk({tv[i].name, "_req_cycles"}, r.req_cyc, tv[i].over > 0 ? tv[i].waits + 1 : 0);
         chk({tv[i].name, "_result"}, r.wb[146:115], tv[i].result);
         chk({tv[i].name, "_wb_bus"}, r.wb, exp_wb(b, tv[i].rd));
         chk({tv[i].name, "_wstrb"}, r.wstrb, tv[i].wstrb);
         if (tv[i].over > 0) begin
            chk({tv[i].name, "_addr"}, r.addr, tv[i].addr);
            chk({tv[i].name, "_wr"}, r.wr, tv[i].wstrb != 0);
            chk({tv[i].name, "_stable"}, r.unstable, 0);
         end
         if (tv[i].wstrb != 0) chk({tv[i].name, "_wdata"}, r.wdata, tv[i].wdata);
      end
      // misaligned word access
      b = mk(8'hA0, 32'h0, 32'h301);
      b.wen = 1;
      do_mem(b, 0, 32'h1122_3344, r);
`ifdef MEM_ALIGN_CHECK_EN
      chk("mis_over_cycle", r.over_cyc, 0);
      chk("mis_req_cycles", r.req_cyc, 0);
      chk("mis_addr_error", r.wb[64], 1);
      chk("mis_badvaddr", r.wb[63:32], 32'h301);
      chk("mis_rf_wen", {r.rfwen, r.wb[152]}, 2'b00);
`else
      chk("mis_over_cycle", r.over_cyc, 2);
      chk("mis_addr", r.addr, 32'h300);
      chk("mis_addr_error", r.wb[64], 0);
      chk("mis_badvaddr", r.wb[63:32], 0);
      chk("mis_result", r.wb[146:115], 32'h1122_3344);
`endif
      // flush during REQ: request held until ack, no MEM_over
      bus = mk(8'hA0, 32'h0, 32'h400); MEM_valid = 1; dm_bus.ack = 0; dm_bus.rdata = 32'h9999_9999;
      overs = 0; reqs = 0;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (k == 2) MEM_valid = 0;
         dm_bus.ack = (k == 4) && dm_bus.req;
         reqs += int'(dm_bus.req);
         @(negedge clk);
         overs += int'(MEM_over);
      end
      @(posedge clk); #1; dm_bus.ack = 0;
      chk("flush_no_over", overs, 0);
      chk("flush_req_cycles", reqs, 4);
      b = mk(8'hA0, 32'h0, 32'h404);
      do_mem(b, 1, 32'h5A5A_0F0F, r);
      chk("after_flush_over", r.over_cyc, 3);
      chk("after_flush_result", r.wb[146:115], 32'h5A5A_0F0F);
      // asynchronous reset while a request is outstanding
      bus = mk(8'hA0, 32'h0, 32'h500); MEM_valid = 1; dm_bus.ack = 0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_mid_req_before", dm_bus.req, 1);
      #2 resetn = 0;
      #1;
      chk("rst_mid_req_drop", dm_bus.req, 0);
      chk("rst_mid_req_over", MEM_over, 0);
      MEM_valid = 0;
      @(posedge clk); #1;
      resetn = 1;
      b = mk(8'h80, 32'h0, 32'h502);
      do_mem(b, 0, 32'h00AB_0000, r);
      chk("after_rst_over", r.over_cyc, 2);
      chk("after_rst_result", r.wb[146:115], 32'hAB);
      // randomized instructions against the model
      for (int i = 0; i < 200; i++) begin
         b = mk(8'($urandom), $urandom, $urandom);
         w = $urandom_range(0, 3);
         rd = $urandom;
         do_mem(b, w, rd, r);
         chk("rnd_over_cycle", r.over_cyc, exp_req(b) ? w + 2 : 0);
         chk("rnd_wb_bus", r.wb, exp_wb(b, rd));
         chk("rnd_side", {r.wdest, r.rfwen, r.pc}, {b.dest, b.wen & !is_err(b), b.pc});
         chk("rnd_wstrb", r.wstrb, exp_wstrb(b));
         if (exp_req(b)) begin
            chk("rnd_addr", r.addr, b.res & ~32'd3);
            chk("rnd_stable", r.unstable, 0);
         end
         if (exp_wstrb(b) != 0) chk("rnd_wdata", r.wdata, exp_wdata(b));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
